// File: rtl/mux_tree_pkg.sv
// ============================================================================
// Module   : mux_tree_pkg
// Purpose  : Shared sizing helpers and lane-slicing macro for the mux tree.
// Revision : 1.0
// ============================================================================
`default_nettype none

package mux_tree_pkg;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result++;
            v = v >> 1;
        end
        return result;
    endfunction

    function automatic int levels(input int num_in);
        return clog2(num_in);
    endfunction

    // All levels share one flat lane bus: raw inputs first, then each level's outputs.
    function automatic int lane_base(input int num_in, input int level);
        return 2 * num_in - 2 * (num_in >> level);
    endfunction

endpackage

`ifndef MUX_TREE_LANE
`define MUX_TREE_LANE(bus, k, w) bus[(k)*(w) +: (w)]
`endif

`default_nettype wire

// File: rtl/mux_tree_level.sv
// ============================================================================
// Module   : mux_tree_level
// Purpose  : One registered 2:1 level of the mux tree with hold-on-stall.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mux_tree_level #(
    parameter int LANES_IN = 2,
    parameter int WIDTH    = 8,
    parameter int SEL_W    = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              en_i,
    input  logic                              valid_i,
    input  logic                              pair_sel_i,
    input  logic [LANES_IN*WIDTH-1:0]         lanes_i,
    input  logic [SEL_W-1:0]                  sel_i,
    output logic [(LANES_IN/2)*WIDTH-1:0]     lanes_o,
    output logic [SEL_W-1:0]                  sel_o,
    output logic                              valid_o
);

    localparam int LANES_OUT = LANES_IN / 2;

    logic [LANES_OUT*WIDTH-1:0] lanes_d;
    logic [LANES_OUT*WIDTH-1:0] lanes_q;
    logic [SEL_W-1:0]           sel_q;
    logic                       valid_q;

    always_comb begin
        lanes_d = '0;
        for (int k = 0; k < LANES_OUT; k++) begin
            `MUX_TREE_LANE(lanes_d, k, WIDTH) = pair_sel_i ? `MUX_TREE_LANE(lanes_i, 2*k+1, WIDTH)
                                                           : `MUX_TREE_LANE(lanes_i, 2*k, WIDTH);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lanes_q <= '0;
            sel_q   <= '0;
            valid_q <= 1'b0;
        end else if (en_i) begin
            lanes_q <= lanes_d;
            sel_q   <= sel_i;
            valid_q <= valid_i;
        end
    end

    assign lanes_o = lanes_q;
    assign sel_o   = sel_q;
    assign valid_o = valid_q;

endmodule

`default_nettype wire

// File: rtl/mux_tree_pipelined.sv
// ============================================================================
// Module   : mux_tree_pipelined
// Purpose  : Pipelined N:1 mux tree with valid/ready and bubble collapsing.
//            Define MUX_TREE_PARITY_EN to add the out_parity output.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mux_tree_pipelined
    import mux_tree_pkg::*;
#(
    parameter int   NUM_IN = 8,
    parameter int   WIDTH  = 8,
    localparam int  SEL_W  = clog2(NUM_IN)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_IN*WIDTH-1:0]  in_data,
    input  logic [SEL_W-1:0]         in_sel,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [SEL_W-1:0]         out_sel,
    output logic                     out_valid,
`ifdef MUX_TREE_PARITY_EN
    output logic                     out_parity,
`endif
    input  logic                     out_ready
);

    localparam int LEVELS      = levels(NUM_IN);
    localparam int TOTAL_LANES = 2 * NUM_IN - 1;

    logic [TOTAL_LANES*WIDTH-1:0] w_stage_data;
    logic [SEL_W-1:0]             w_stage_sel [0:LEVELS];
    logic [LEVELS:0]              w_stage_valid;
    logic [LEVELS:0]              w_en;

    assign w_stage_data[NUM_IN*WIDTH-1:0] = in_data;
    assign w_stage_sel[0]                 = in_sel;
    assign w_stage_valid[0]               = in_valid;

    // A level may load when it is empty or its contents move on this edge.
    always_comb begin
        w_en[LEVELS] = out_ready;
        for (int l = LEVELS - 1; l >= 0; l--) begin
            w_en[l] = !w_stage_valid[l+1] || w_en[l+1];
        end
    end

    assign in_ready = w_en[0];

    for (genvar l = 0; l < LEVELS; l++) begin : g_level
        localparam int LANES_IN = NUM_IN >> l;
        localparam int IN_LO    = lane_base(NUM_IN, l) * WIDTH;
        localparam int OUT_LO   = lane_base(NUM_IN, l + 1) * WIDTH;

        mux_tree_level #(
            .LANES_IN (LANES_IN),
            .WIDTH    (WIDTH),
            .SEL_W    (SEL_W)
        ) u_level (
            .clk        (clk),
            .rst        (rst),
            .en_i       (w_en[l]),
            .valid_i    (w_stage_valid[l]),
            .pair_sel_i (w_stage_sel[l][l]),
            .lanes_i    (w_stage_data[IN_LO +: LANES_IN*WIDTH]),
            .sel_i      (w_stage_sel[l]),
            .lanes_o    (w_stage_data[OUT_LO +: (LANES_IN/2)*WIDTH]),
            .sel_o      (w_stage_sel[l+1]),
            .valid_o    (w_stage_valid[l+1])
        );
    end

    assign out_data  = w_stage_data[(TOTAL_LANES-1)*WIDTH +: WIDTH];
    assign out_sel   = w_stage_sel[LEVELS];
    assign out_valid = w_stage_valid[LEVELS];

`ifdef MUX_TREE_PARITY_EN
    localparam int LAST_LO = lane_base(NUM_IN, LEVELS - 1) * WIDTH;

    logic [WIDTH-1:0] w_last_pick;
    logic             parity_d;
    logic             parity_q;

    // Parity of the final level's selection, registered alongside out_data.
    assign w_last_pick = w_stage_sel[LEVELS-1][LEVELS-1] ? w_stage_data[LAST_LO+WIDTH +: WIDTH]
                                                         : w_stage_data[LAST_LO +: WIDTH];
    assign parity_d    = ^w_last_pick;

    always_ff @(posedge clk) begin
        if (rst) begin
            parity_q <= 1'b0;
        end else if (w_en[LEVELS-1]) begin
            parity_q <= parity_d;
        end
    end

    assign out_parity = parity_q;
`endif

endmodule

`default_nettype wire
